fifo_sync_param: RTL and testbench

//  Parametrised single-clock FIFO: storage array, wrap-bit read/write pointers, full/empty,

---
 rtl/fifo_sync_param.sv | 72 +++++++
 tb/tb_fifo_sync_param.sv | 121 ++++++++++++
 2 files changed

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with wrap-bit pointers, registered status, sticky errors
// Read data is registered; status flags are computed from next-state values and registered.
module fifo_sync_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_clear,
    input  logic                       i_wen,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_ren,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_rvalid,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_almost_full,
    output logic                       o_almost_empty,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_overflow,
    output logic                       o_underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE = (AW+1)'(AE_LEVEL);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr, r_rd_ptr, r_count;
    logic [AW:0]      w_wr_ptr_nxt, w_rd_ptr_nxt, w_count_nxt;
    logic             w_wr_acc, w_rd_acc;
    assign w_wr_acc = i_wen & ~o_full & ~i_clear;
    assign w_rd_acc = i_ren & ~o_empty & ~i_clear;
    always_comb begin
        w_wr_ptr_nxt = i_clear ? '0 : r_wr_ptr + (AW+1)'(w_wr_acc);
        w_rd_ptr_nxt = i_clear ? '0 : r_rd_ptr + (AW+1)'(w_rd_acc);
        w_count_nxt  = i_clear ? '0 : r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
    end
    // storage is deliberately left out of reset
    always_ff @(posedge i_clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            o_rdata        <= '0;
            o_rvalid       <= 1'b0;
            o_full         <= 1'b0;
            o_empty        <= 1'b1;
            o_almost_full  <= 1'b0;
            o_almost_empty <= 1'b1;
            o_overflow     <= 1'b0;
            o_underflow    <= 1'b0;
        end else begin
            r_wr_ptr       <= w_wr_ptr_nxt;
            r_rd_ptr       <= w_rd_ptr_nxt;
            r_count        <= w_count_nxt;
            if (w_rd_acc) o_rdata <= r_mem[r_rd_ptr[AW-1:0]];
            o_rvalid       <= w_rd_acc;
            o_empty        <= w_wr_ptr_nxt == w_rd_ptr_nxt;
            o_full         <= (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                              (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
            o_almost_full  <= w_count_nxt >= AF;
            o_almost_empty <= w_count_nxt <= AE;
            o_overflow     <= ~i_clear & (o_overflow | (i_wen & o_full));
            o_underflow    <= ~i_clear & (o_underflow | (i_ren & o_empty));
        end
    end
    assign o_count = r_count;
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed stimulus with a read-data scoreboard checked by a separate monitor
module tb_fifo_sync_param;
    logic       clk = 1'b0, rst_n = 1'b0, clear = 1'b0, wen = 1'b0, ren = 1'b0;
    logic [7:0] wdata = '0, rdata;
    logic       rvalid, full, empty, afull, aempty, ovf, unf;
    logic [3:0] count;
    int         n_checks = 0, n_err = 0;
    logic [7:0] model[$], exp_q[$];

    fifo_sync_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_wen(wen), .i_wdata(wdata), .i_ren(ren),
        .o_rdata(rdata), .o_rvalid(rvalid), .o_full(full), .o_empty(empty),
        .o_almost_full(afull), .o_almost_empty(aempty), .o_count(count),
        .o_overflow(ovf), .o_underflow(unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && rvalid) begin
            if (exp_q.size() == 0) chk("unexpected_rvalid", rdata, 32'hFFFF_FFFF);
            else chk("rdata", rdata, exp_q.pop_front());
        end
    end

    task automatic cycle(input bit c, input bit w, input bit r, input logic [7:0] d);
        bit wr_ok, rd_ok;
        clear = c; wen = w; ren = r; wdata = d;
        wr_ok = !c && w && model.size() < 8;
        rd_ok = !c && r && model.size() > 0;
        if (c) model.delete();
        if (rd_ok) exp_q.push_back(model.pop_front());
        if (wr_ok) model.push_back(d);
        @(posedge clk); #1;
        clear = 0; wen = 0; ren = 0;
    endtask

    task automatic status(input string tag, input int cnt, input bit f, input bit e,
                          input bit af, input bit ae, input bit o, input bit u);
        chk({tag, "_count"}, count, cnt);
        chk({tag, "_full"}, full, f);
        chk({tag, "_empty"}, empty, e);
        chk({tag, "_afull"}, afull, af);
        chk({tag, "_aempty"}, aempty, ae);
        chk({tag, "_ovf"}, ovf, o);
        chk({tag, "_unf"}, unf, u);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        status("rst0", 0, 0, 1, 0, 1, 0, 0);
        chk("rst0_rvalid", rvalid, 0);
        chk("rst0_rdata", rdata, 0);
        rst_n = 1;
        cycle(0, 1, 0, 8'hC1);
        cycle(0, 1, 0, 8'hC2);
        cycle(0, 0, 1, 0);
        rst_n = 0;
        exp_q.delete(); model.delete();
        #1;
        status("rst1", 0, 0, 1, 0, 1, 0, 0);
        chk("rst1_rvalid", rvalid, 0);
        @(posedge clk); #1;
        rst_n = 1;
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 0, 8'(i));
            status("fill", i, i == 8, 0, i >= 6, i <= 2, 0, 0);
        end
        cycle(0, 1, 0, 8'h99);
        status("ovf9", 8, 1, 0, 1, 0, 1, 0);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 0, 1, 0);
            chk("drain_rvalid", rvalid, 1);
            chk("drain_count", count, 8 - i);
        end
        status("drained", 0, 0, 1, 0, 1, 1, 0);
        cycle(0, 0, 1, 0);
        chk("unf_rvalid", rvalid, 0);
        status("unf", 0, 0, 1, 0, 1, 1, 1);
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 8'h10 + 8'(i));
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 1, 8'h20 + 8'(i));
            chk("wrap_count", count, 3);
        end
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        status("wrap_end", 0, 0, 1, 0, 1, 0, 0);
        cycle(0, 1, 1, 8'hA5);
        chk("we_rvalid", rvalid, 0);
        status("we", 1, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 7; i++) cycle(0, 1, 0, 8'hB0 + 8'(i));
        chk("full8", full, 1);
        cycle(0, 1, 1, 8'h5A);
        chk("wf_rvalid", rvalid, 1);
        chk("wf_rdata", rdata, 8'hA5);
        status("wf", 7, 0, 0, 1, 0, 1, 1);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("pre_clear_count", count, 5);
        cycle(1, 1, 1, 8'hEE);
        chk("clr_rvalid", rvalid, 0);
        status("clr", 0, 0, 1, 0, 1, 0, 0);
        cycle(0, 1, 0, 8'h77);
        cycle(0, 0, 1, 0);
        chk("post_clr_rdata", rdata, 8'h77);
        status("post_clr", 0, 0, 1, 0, 1, 0, 0);
        @(posedge clk); #1;
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
